// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter slice.
//   H_DISP_DEF / V_DISP_DEF : default active resolution (320x240)
//   FB_DEPTH                : number of pixels held in the frame buffer
//   PIX_W                   : pixel width (RGB444)
//   FB_ADDR_W               : minimum address width covering FB_DEPTH
//   gnt_state_t             : frame-buffer port owner for the current cycle
`timescale 1ns/1ps
package vga_pkg;

  localparam int H_DISP_DEF = 320;
  localparam int V_DISP_DEF = 240;
  localparam int FB_DEPTH   = H_DISP_DEF * V_DISP_DEF;
  localparam int PIX_W      = 12;
  localparam int FB_ADDR_W  = $clog2(FB_DEPTH);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } gnt_state_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register used to carry timing flags alongside the
// frame-buffer read pipeline.
//   i_clk   : clock
//   i_rstn  : asynchronous active-low reset; every stage loads RST_VAL
//   i_din   : WIDTH-bit input word
//   o_dout  : i_din delayed by DEPTH cycles
`timescale 1ns/1ps
module vga_sync_delay #(
  parameter int                DEPTH   = 2,
  parameter int                WIDTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= RST_VAL;
      end
    end else begin
      stage_reg[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign o_dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port frame-buffer RAM between the VGA display read
// path and a valid/ready pixel writer. Display reads own the port during
// active video; writes are granted on blanking cycles. Timing flags are
// delayed to line up with the returned pixel data.
//   i_clk, i_rstn          : pixel clock, asynchronous active-low reset
//   i_x, i_y               : timing-generator counters
//   i_video/hsync/vsync    : timing-generator flags (syncs active-low)
//   i_wr_valid/addr/data   : writer request; o_wr_ready accepts it
//   o_mem_addr/we/wdata    : registered RAM port
//   i_mem_rdata            : RAM read data, RD_LAT cycles after the address
//   o_pixel                : pixel to the DAC, 0 outside active video
//   o_video/hsync/vsync    : flags delayed by RD_LAT+2 cycles
//   o_oob_cnt              : saturating count of accepted out-of-range writes
`timescale 1ns/1ps
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = PIX_W,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  input  logic              i_video,
  input  logic              i_hsync,
  input  logic              i_vsync,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_video,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic [15:0]       o_oob_cnt
);

  // End-to-end latency: address register, RD_LAT of RAM, output register.
  localparam int          LAT      = RD_LAT + 2;
  localparam logic [31:0] DEPTH_U  = 32'(H_DISP * V_DISP);

  gnt_state_t        gnt_reg;
  logic [ADDR_W-1:0] disp_addr;
  logic              wr_in_range;
  logic [RD_LAT-1:0] rd_vld_reg;
  logic [2:0]        sync_dly;

  // y*H_DISP + x at 20 bits, truncated to the RAM address width.
  // H_DISP is constant, so this folds to shifts and adds.
  assign disp_addr   = ADDR_W'(20'(i_y) * 20'(H_DISP) + 20'(i_x));
  assign wr_in_range = {{(32-ADDR_W){1'b0}}, i_wr_addr} < DEPTH_U;

  // Writer may only proceed during blanking, and never while in reset.
  assign o_wr_ready = i_rstn & ~i_video;

  // Grant FSM with registered RAM-port outputs. Display wins outright
  // whenever i_video is high; there is no bubble on the video->blank edge.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gnt_reg     <= GNT_IDLE;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_oob_cnt   <= '0;
    end else if (i_video) begin
      gnt_reg    <= GNT_DISP;
      o_mem_addr <= disp_addr;
      o_mem_we   <= 1'b0;
    end else if (i_wr_valid) begin
      gnt_reg     <= GNT_WR;
      o_mem_addr  <= i_wr_addr;
      o_mem_wdata <= i_wr_data;
      // Out-of-range writes still complete the handshake so the writer
      // cannot lock up; they are dropped and counted instead.
      o_mem_we    <= wr_in_range;
      if (!wr_in_range && (o_oob_cnt != 16'hFFFF)) begin
        o_oob_cnt <= o_oob_cnt + 16'd1;
      end
    end else begin
      gnt_reg  <= GNT_IDLE;
      o_mem_we <= 1'b0;
    end
  end

  // Tracks which RAM accesses were display reads, aligned with the cycle
  // their data is present on i_mem_rdata.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_vld_reg <= '0;
    end else begin
      rd_vld_reg[0] <= (gnt_reg == GNT_DISP);
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_reg[i] <= rd_vld_reg[i-1];
      end
    end
  end

  // First LAT-1 stages of the flag pipeline; the last stage is registered
  // together with o_pixel so that all DAC-side outputs change on one edge.
  vga_sync_delay #(
    .DEPTH   (LAT - 1),
    .WIDTH   (3),
    .RST_VAL (3'b011)
  ) u_sync_delay (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_din  ({i_video, i_hsync, i_vsync}),
    .o_dout (sync_dly)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_pixel <= '0;
      o_video <= 1'b0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
    end else begin
      o_pixel <= (sync_dly[2] && rd_vld_reg[RD_LAT-1]) ? i_mem_rdata : '0;
      o_video <= sync_dly[2];
      o_hsync <= sync_dly[1];
      o_vsync <= sync_dly[0];
    end
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two requesters: the VGA display read path, driven by the timing generator's x/y/video/sync outputs, and a pixel writer (camera or image-processing stage) using a valid/ready handshake.
- Display reads have absolute priority during active video. Writes use blanking cycles.
- Re-aligns hsync/vsync/video with the returned pixel data so the DAC/pins see coherent timing.

Parameters:
- H_DISP, 320, active pixels per line; must match the timing generator.
- V_DISP, 240, active lines per frame.
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= H_DISP*V_DISP.
- DATA_W, 12, pixel width (RGB444).
- RD_LAT, 1, RAM read latency in cycles, from registered address to valid rdata (1 or 2).

Ports:
- i_clk  in  1  pixel clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_x  in  10  horizontal counter from the timing generator.
- i_y  in  10  vertical counter from the timing generator.
- i_video  in  1  active-region flag from the timing generator.
- i_hsync  in  1  active-low hsync from the timing generator.
- i_vsync  in  1  active-low vsync from the timing generator.
- i_wr_valid  in  1  writer has a pixel.
- i_wr_addr  in  ADDR_W  linear write address (y*H_DISP + x).
- i_wr_data  in  DATA_W  write pixel.
- o_wr_ready  out  1  write accepted this cycle when asserted together with i_wr_valid.
- o_mem_addr  out  ADDR_W  registered RAM address.
- o_mem_we  out  1  registered RAM write enable.
- o_mem_wdata  out  DATA_W  registered RAM write data.
- i_mem_rdata  in  DATA_W  RAM read data.
- o_pixel  out  DATA_W  pixel to the DAC; 0 outside active video.
- o_video  out  1  delayed video flag.
- o_hsync  out  1  delayed hsync.
- o_vsync  out  1  delayed vsync.
- o_oob_cnt  out  16  saturating count of accepted out-of-range writes.

Behaviour:
- Reset is asynchronous, active-low, on i_rstn; the clock is i_clk. All regs clear on reset:
  - o_mem_addr=0, o_mem_we=0, o_mem_wdata=0, o_pixel=0, o_video=0, o_oob_cnt=0.
  - o_hsync=1 and o_vsync=1, all delay-line stages at the inactive level.
- o_wr_ready = !i_video, combinational. It is forced 0 while i_rstn=0.
- Grant FSM has states GNT_IDLE, GNT_DISP and GNT_WR, registered each cycle. Priority is DISP > WR > IDLE:
  - i_video=1 -> GNT_DISP: o_mem_addr <= i_y*H_DISP + i_x, o_mem_we <= 0.
  - else i_wr_valid=1 -> GNT_WR: o_mem_addr <= i_wr_addr, o_mem_wdata <= i_wr_data. o_mem_we <= 1 only if i_wr_addr < H_DISP*V_DISP. Otherwise the write is accepted (handshake completes), we=0, and o_oob_cnt increments, saturating at 0xFFFF.
  - else -> GNT_IDLE: o_mem_we <= 0, address held.
- Address arithmetic: y*H_DISP is computed at 20 bits and truncated to ADDR_W. H_DISP is a constant, so a shift-add is acceptable. No multiplier pipelining is needed at 25 MHz.
- Total latency L = RD_LAT + 2 cycles, from inputs sampled at edge t to outputs at edge t+L:
  - edge t+1: address registered.
  - cycles t+1 .. t+RD_LAT: RAM access; rdata valid during cycle t+1+RD_LAT.
  - edge t+2+RD_LAT: o_pixel <= (video delayed by L-1) ? i_mem_rdata : 0.
- i_video, i_hsync and i_vsync pass through an L-stage delay line, so o_video, o_hsync and o_vsync are exact L-cycle-delayed copies.
- Simultaneous i_video=1 and i_wr_valid=1: display wins and o_wr_ready=0. The writer must hold valid/addr/data stable until ready.
- The writer is never starved beyond one active line: ready returns on the first blanking cycle.
- Transition from video to blank: a write may be granted on the first cycle with i_video=0. There is no bubble.
- Reset mid-frame: the pipeline flushes to inactive values. After release, outputs are valid L cycles after the first sampled input. Any pending write is not accepted during reset.
- i_x >= H_DISP or i_y >= V_DISP while i_video=1 indicates a generator misconfiguration. The address is computed anyway and no error is flagged.

Decomposition:
- Shared package vga_pkg holds:
  - H_DISP and V_DISP defaults.
  - FB_DEPTH = H_DISP*V_DISP.
  - the pixel width.
  - the grant state enum {GNT_IDLE, GNT_DISP, GNT_WR}.
- One sub-module, vga_sync_delay: parameterised depth and width, per-bit reset value. It delays {video, hsync, vsync}.

Test Plan:
- Reset release with i_video=0 and no write -> o_hsync=1, o_vsync=1, o_pixel=0, o_mem_we=0, o_oob_cnt=0.
- i_video=1, x=5, y=2 at edge t; RAM model returns addr+0x100 -> o_mem_addr=645 at t+1; o_pixel=0x385 at t+3 (RD_LAT=1); o_video/o_hsync equal the inputs delayed 3 cycles.
- i_wr_valid=1 held across active video -> o_wr_ready=0 until the first blanking cycle; then one write at addr=100, data=0xABC gives o_mem_we=1 for exactly 1 cycle.
- Write with i_wr_addr=76800 during blanking -> handshake completes, o_mem_we=0, o_oob_cnt=1. After 65536 such writes, o_oob_cnt stays at 0xFFFF.
- Full 320x240 frame written during blanking, then displayed -> every o_pixel in the active region matches the written value and is 0 in blanking.
- Assert i_rstn=0 mid-line with a write pending -> all outputs return to reset values asynchronously and no write occurs. After release, the first valid pixel appears at L cycles.
